// File: rtl/pc_unit_if.sv
// ============================================================================
// Module   : pc_unit_if
// Brief    : Fetch-control bundle between decoder/ALU and the program counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              excp;
  logic              eret;
  logic [2:0]        kind;
  logic [2:0]        cond;
  logic [XLEN-1:0]   cmp_val;
  logic [15:0]       imm;
  logic [25:0]       idx;
  logic [XLEN-1:0]   reg_target;

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   link;
  logic [XLEN-1:0]   epc;
  logic [c_CNT_W-1:0] ras_count;
  logic              taken;
  logic              ras_err;
  logic              misalign;

  modport master (
    output stall, excp, eret, kind, cond, cmp_val, imm, idx, reg_target,
    input  pc, link, epc, ras_count, taken, ras_err, misalign
  );

  modport slave (
    input  stall, excp, eret, kind, cond, cmp_val, imm, idx, reg_target,
    output pc, link, epc, ras_count, taken, ras_err, misalign
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : CPU32 program counter with stall, exception PC and circular RAS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] START_ADRS = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXCP_ADRS  = 32'h0000_0080,
  parameter int              RAS_DEPTH  = 4
) (
  input  wire         clk_cpu,
  input  wire         reset,
  pc_unit_if.slave    bus
);

  localparam int c_PTR_W = $clog2(RAS_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(RAS_DEPTH);

  localparam logic [2:0] c_K_SEQ   = 3'd0;
  localparam logic [2:0] c_K_BR    = 3'd1;
  localparam logic [2:0] c_K_JMP   = 3'd2;
  localparam logic [2:0] c_K_JR    = 3'd3;
  localparam logic [2:0] c_K_CALL  = 3'd4;
  localparam logic [2:0] c_K_CALLR = 3'd5;
  localparam logic [2:0] c_K_RET   = 3'd6;

  localparam logic [2:0] c_C_EQ  = 3'd0;
  localparam logic [2:0] c_C_NE  = 3'd1;
  localparam logic [2:0] c_C_LEZ = 3'd2;
  localparam logic [2:0] c_C_GTZ = 3'd3;
  localparam logic [2:0] c_C_LTZ = 3'd4;
  localparam logic [2:0] c_C_GEZ = 3'd5;

  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_epc;
  logic [XLEN-1:0]    r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_taken;
  logic               r_ras_err;
  logic               r_misalign;

  logic [XLEN-1:0]    w_next;
  logic [XLEN-1:0]    w_brnc;
  logic [XLEN-1:0]    w_jmp;
  logic [XLEN-1:0]    w_pop_val;
  logic               w_neg;
  logic               w_zero;
  logic               w_cond_true;
  logic               w_reg_jmp;
  logic [XLEN-1:0]    w_pc_nxt;
  logic [XLEN-1:0]    w_epc_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_taken;
  logic               w_ras_err;
  logic               w_misalign;

  assign w_next    = r_pc + XLEN'(4);
  assign w_brnc    = w_next + {{(XLEN-18){bus.imm[15]}}, bus.imm, 2'b00};
  assign w_pop_val = r_ras[r_ptr - c_PTR_W'(1)];
  assign w_neg     = bus.cmp_val[XLEN-1];
  assign w_zero    = (bus.cmp_val == '0);

  // Jump target keeps the current 256 MB region when XLEN leaves bits above the index.
  generate
    if (XLEN > 28) begin : g_jmp_hi
      assign w_jmp = {r_pc[XLEN-1:28], bus.idx, 2'b00};
    end else begin : g_jmp_lo
      assign w_jmp = {bus.idx, 2'b00};
    end
  endgenerate

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      c_C_EQ:  w_cond_true = w_zero;
      c_C_NE:  w_cond_true = !w_zero;
      c_C_LEZ: w_cond_true = w_neg || w_zero;
      c_C_GTZ: w_cond_true = !w_neg && !w_zero;
      c_C_LTZ: w_cond_true = w_neg;
      c_C_GEZ: w_cond_true = !w_neg;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_nxt   = w_next;
    w_epc_nxt  = r_epc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_taken    = 1'b0;
    w_ras_err  = 1'b0;
    w_misalign = 1'b0;
    w_reg_jmp  = 1'b0;

    if (bus.excp) begin
      w_pc_nxt  = EXCP_ADRS;
      w_epc_nxt = r_pc;
      w_taken   = 1'b1;
    end else if (bus.stall) begin
      w_pc_nxt = r_pc;
    end else if (bus.eret) begin
      w_pc_nxt = r_epc;
      w_taken  = 1'b1;
    end else begin
      case (bus.kind)
        c_K_BR: begin
          if (w_cond_true) begin
            w_pc_nxt = w_brnc;
            w_taken  = 1'b1;
          end
        end
        c_K_JMP: begin
          w_pc_nxt = w_jmp;
          w_taken  = 1'b1;
        end
        c_K_JR: begin
          w_reg_jmp = 1'b1;
        end
        c_K_CALL: begin
          w_pc_nxt = w_jmp;
          w_taken  = 1'b1;
          w_push   = 1'b1;
        end
        c_K_CALLR: begin
          w_reg_jmp = 1'b1;
          w_push    = 1'b1;
        end
        c_K_RET: begin
          if (r_count != '0) begin
            w_pc_nxt = w_pop_val;
            w_taken  = 1'b1;
            w_pop    = 1'b1;
          end else begin
            w_reg_jmp = 1'b1;
            w_ras_err = 1'b1;
          end
        end
        default: begin
          w_pc_nxt = w_next;
        end
      endcase

      // A misaligned register target traps instead of jumping and suppresses the push.
      if (w_reg_jmp) begin
        w_taken = 1'b1;
        if (bus.reg_target[1:0] != 2'b00) begin
          w_pc_nxt   = EXCP_ADRS;
          w_epc_nxt  = r_pc;
          w_misalign = 1'b1;
          w_push     = 1'b0;
        end else begin
          w_pc_nxt = bus.reg_target;
        end
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      r_pc       <= START_ADRS;
      r_epc      <= '0;
      r_ptr      <= '0;
      r_count    <= '0;
      r_taken    <= 1'b0;
      r_ras_err  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_epc      <= w_epc_nxt;
      r_taken    <= w_taken;
      r_ras_err  <= w_ras_err;
      r_misalign <= w_misalign;
      if (w_push) begin
        r_ptr <= r_ptr + c_PTR_W'(1);
        if (r_count != c_FULL) begin
          r_count <= r_count + c_CNT_W'(1);
        end
      end else if (w_pop) begin
        r_ptr   <= r_ptr - c_PTR_W'(1);
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // When full, the pointer has wrapped onto the oldest entry, so a push overwrites it.
  always_ff @(posedge clk_cpu) begin
    if (!reset && w_push) begin
      r_ras[r_ptr] <= w_next;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.link      = w_next;
  assign bus.epc       = r_epc;
  assign bus.ras_count = r_count;
  assign bus.taken     = r_taken;
  assign bus.ras_err   = r_ras_err;
  assign bus.misalign  = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed scoreboard bench for pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

  typedef struct packed {
    logic        cp;  logic [31:0] pc;
    logic        ce;  logic [31:0] epc;
    logic        cc;  logic [2:0]  cnt;
    logic        ct;  logic        tk;
    logic        cr;  logic        err;
    logic        cm;  logic        mis;
  } exp_t;

  logic clk_cpu;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t  exp_q[$];
  string name_q[$];

  pc_unit_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .XLEN      (32),
    .START_ADRS(32'h0000_0000),
    .EXCP_ADRS (32'h0000_0080),
    .RAS_DEPTH (4)
  ) dut (
    .clk_cpu(clk_cpu),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  // -1 in any slot means the field is not checked for that cycle.
  function automatic exp_t ex(input longint pc, input longint epc, input longint cnt,
                              input longint tk, input longint err, input longint mis);
    exp_t e;
    e = '0;
    e.cp = (pc  >= 0); e.pc  = 32'(pc);
    e.ce = (epc >= 0); e.epc = 32'(epc);
    e.cc = (cnt >= 0); e.cnt = 3'(cnt);
    e.ct = (tk  >= 0); e.tk  = 1'(tk);
    e.cr = (err >= 0); e.err = 1'(err);
    e.cm = (mis >= 0); e.mis = 1'(mis);
    return e;
  endfunction

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic st, input logic ex_i,
                      input logic er, input logic [2:0] k, input logic [2:0] c,
                      input logic [31:0] cv, input logic [15:0] im, input logic [25:0] ix,
                      input logic [31:0] rt, input exp_t e);
    @(negedge clk_cpu);
    reset          = rst;
    bus.stall      = st;
    bus.excp       = ex_i;
    bus.eret       = er;
    bus.kind       = k;
    bus.cond       = c;
    bus.cmp_val    = cv;
    bus.imm        = im;
    bus.idx        = ix;
    bus.reg_target = rt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk_cpu);
  endtask

  // Monitor: one expectation per clock edge, sampled after the edge settles.
  always @(posedge clk_cpu) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.cp) begin
        check(nm, "pc", bus.pc, e.pc);
        check(nm, "link", bus.link, e.pc + 32'd4);
      end
      if (e.ce) check(nm, "epc", bus.epc, e.epc);
      if (e.cc) check(nm, "ras_count", 32'(bus.ras_count), 32'(e.cnt));
      if (e.ct) check(nm, "taken", 32'(bus.taken), 32'(e.tk));
      if (e.cr) check(nm, "ras_err", 32'(bus.ras_err), 32'(e.err));
      if (e.cm) check(nm, "misalign", 32'(bus.misalign), 32'(e.mis));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.excp = 1'b0; bus.eret = 1'b0;
    bus.kind = 3'd0; bus.cond = 3'd0; bus.cmp_val = '0;
    bus.imm = '0; bus.idx = '0; bus.reg_target = '0;

    // Reset and sequential fetch
    step("rst0", 1,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(0,0,0,0,0,0));
    step("rst1", 1,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(0,0,0,0,0,0));
    step("seq4", 0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(4,0,0,0,0,0));
    step("seq8", 0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(8,0,0,0,0,0));
    step("seq12",0,0,0,0, 3'd7,3'd0,32'h0,16'h0,26'h0,32'h0, ex(12,0,0,0,0,0));

    // Conditional branches around pc=0x100, imm=-2 words
    step("jmp100",  0,0,0,0, 3'd2,3'd0,32'h0,16'h0,26'h40,32'h0, ex(32'h100,-1,-1,1,-1,-1));
    step("bltz_t",  0,0,0,0, 3'd1,3'd4,32'hFFFF_FFFF,16'hFFFE,26'h0,32'h0, ex(32'hFC,-1,-1,1,-1,-1));
    step("jmp100b", 0,0,0,0, 3'd2,3'd0,32'h0,16'h0,26'h40,32'h0, ex(32'h100,-1,-1,1,-1,-1));
    step("bltz_n",  0,0,0,0, 3'd1,3'd4,32'h0,16'hFFFE,26'h0,32'h0, ex(32'h104,-1,-1,0,-1,-1));
    step("bgez_t",  0,0,0,0, 3'd1,3'd5,32'h0,16'hFFFE,26'h0,32'h0, ex(32'h100,-1,-1,1,-1,-1));
    step("bgtz_n",  0,0,0,0, 3'd1,3'd3,32'h0,16'hFFFE,26'h0,32'h0, ex(32'h104,-1,-1,0,-1,-1));
    step("bne_t",   0,0,0,0, 3'd1,3'd1,32'h5,16'h0003,26'h0,32'h0, ex(32'h114,-1,-1,1,-1,-1));

    // Call nesting overflows the 4-entry RAS, then unwinds
    step("jmp10", 0,0,0,0, 3'd2,3'd0,32'h0,16'h0,26'h4,32'h0,  ex(32'h10,-1,0,1,-1,-1));
    step("call1", 0,0,0,0, 3'd4,3'd0,32'h0,16'h0,26'h8,32'h0,  ex(32'h20,-1,1,1,-1,-1));
    step("call2", 0,0,0,0, 3'd4,3'd0,32'h0,16'h0,26'hC,32'h0,  ex(32'h30,-1,2,1,-1,-1));
    step("call3", 0,0,0,0, 3'd4,3'd0,32'h0,16'h0,26'h10,32'h0, ex(32'h40,-1,3,1,-1,-1));
    step("call4", 0,0,0,0, 3'd4,3'd0,32'h0,16'h0,26'h14,32'h0, ex(32'h50,-1,4,1,-1,-1));
    step("call5", 0,0,0,0, 3'd4,3'd0,32'h0,16'h0,26'h18,32'h0, ex(32'h60,-1,4,1,-1,-1));
    step("ret1",  0,0,0,0, 3'd6,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h54,-1,3,1,0,-1));
    step("ret2",  0,0,0,0, 3'd6,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h44,-1,2,1,0,-1));
    step("ret3",  0,0,0,0, 3'd6,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h34,-1,1,1,0,-1));
    step("ret4",  0,0,0,0, 3'd6,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h24,-1,0,1,0,-1));
    step("ret5",  0,0,0,0, 3'd6,3'd0,32'h0,16'h0,26'h0,32'h200,ex(32'h200,-1,0,1,1,0));
    step("post",  0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h204,-1,0,0,0,0));

    // Exception and exception return
    step("jmp40",   0,0,0,0, 3'd2,3'd0,32'h0,16'h0,26'h10,32'h0, ex(32'h40,-1,-1,1,-1,-1));
    step("excp_st", 0,1,1,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h80,32'h40,-1,1,-1,-1));
    step("eret",    0,0,0,1, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h40,32'h40,-1,1,-1,-1));
    step("seq44",   0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h44,32'h40,-1,0,-1,-1));
    step("ex_eret", 0,0,1,1, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0,  ex(32'h80,32'h44,-1,1,-1,-1));

    // Misaligned register targets
    step("jmp10m",   0,0,0,0, 3'd2,3'd0,32'h0,16'h0,26'h4,32'h0, ex(32'h10,-1,0,-1,-1,0));
    step("jr_mis",   0,0,0,0, 3'd3,3'd0,32'h0,16'h0,26'h0,32'h202, ex(32'h80,32'h10,0,-1,-1,1));
    step("mis_clr",  0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(32'h84,32'h10,0,-1,-1,0));
    step("jmp10n",   0,0,0,0, 3'd2,3'd0,32'h0,16'h0,26'h4,32'h0, ex(32'h10,-1,0,-1,-1,-1));
    step("callm",    0,0,0,0, 3'd4,3'd0,32'h0,16'h0,26'h8,32'h0, ex(32'h20,-1,1,-1,-1,-1));
    step("callr_mis",0,0,0,0, 3'd5,3'd0,32'h0,16'h0,26'h0,32'h202, ex(32'h80,32'h20,1,-1,-1,1));
    step("ret_m",    0,0,0,0, 3'd6,3'd0,32'h0,16'h0,26'h0,32'h0, ex(32'h14,-1,0,1,0,0));

    // Stall hold and address wrap
    step("jr_top", 0,0,0,0, 3'd3,3'd0,32'h0,16'h0,26'h0,32'hFFFF_FFFC, ex(32'hFFFF_FFFC,-1,-1,1,-1,-1));
    for (int i = 0; i < 3; i++)
      step("stall", 0,1,0,0, 3'd2,3'd0,32'h0,16'h0,26'h4,32'h0, ex(32'hFFFF_FFFC,-1,-1,0,0,0));
    step("wrap",   0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(32'h0,-1,-1,0,-1,-1));
    step("jr_top2",0,0,0,0, 3'd3,3'd0,32'h0,16'h0,26'h0,32'hFFFF_FFFC, ex(32'hFFFF_FFFC,-1,-1,1,-1,-1));
    step("stall2", 0,1,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(32'hFFFF_FFFC,-1,-1,0,-1,-1));
    step("rst_st", 1,1,1,0, 3'd4,3'd0,32'h0,16'h0,26'h8,32'h0, ex(32'h0,32'h0,0,0,0,0));
    step("seq_r",  0,0,0,0, 3'd0,3'd0,32'h0,16'h0,26'h0,32'h0, ex(32'h4,32'h0,0,0,0,0));

    @(negedge clk_cpu);
    @(negedge clk_cpu);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised next-generation program counter for the CPU32 fetch path. Each cycle it selects the next fetch address from sequential, conditional-branch, absolute-jump, register-jump, call/return, exception and exception-return sources. It adds a stall hold, an exception PC register and a circular return-address stack (RAS). It sits between the decoder/ALU and instruction memory, and takes pre-decoded branch controls instead of raw opcodes.

## Interface
- XLEN, 32, address/data width (≥ 28)
- START_ADRS, 32'h0000_0000, PC value after reset
- EXCP_ADRS, 32'h0000_0080, exception vector
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥ 2)
- clk_cpu  in  1  CPU clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC, EPC and RAS
- excp  in  1  external exception request
- eret  in  1  return from exception
- kind  in  3  0 seq, 1 cond branch, 2 jump, 3 jump-reg, 4 call, 5 call-reg, 6 return, 7 reserved (= seq)
- cond  in  3  0 eq0, 1 ne0, 2 lez, 3 gtz, 4 ltz, 5 gez, 6/7 never
- cmp_val  in  XLEN  signed ALU result tested by cond
- imm  in  16  branch offset, words
- idx  in  26  jump index
- reg_target  in  XLEN  register jump target
- pc  out  XLEN  current fetch address
- link  out  XLEN  pc+4, combinational
- epc  out  XLEN  saved PC of last exception
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- taken  out  1  registered; next PC came from a non-sequential source
- ras_err  out  1  registered one-cycle pulse: return with empty RAS
- misalign  out  1  registered one-cycle pulse: register target not word-aligned

## Operation
- Derived addresses:
  - next = pc+4, modulo 2^XLEN.
  - brnc = next + (sign-extend(imm) << 2).
  - jmp = {pc[XLEN-1:28], idx, 2'b00}.
- Priority per cycle:
  1. reset
  2. excp
  3. stall
  4. eret
  5. kind
- reset: pc=START_ADRS, epc=0, RAS emptied (ras_count=0, pointer 0), taken=ras_err=misalign=0.
- excp: pc←EXCP_ADRS, epc←pc, taken=1. RAS unchanged. excp wins even when stall is high.
- stall: all state held. Pulse outputs return to 0.
- eret: pc←epc, taken=1.
- kind 0/7: pc←next.
- kind 1: pc←brnc if cond is true on signed cmp_val, else next. taken reflects the outcome.
- kind 2: pc←jmp.
- kind 3: pc←reg_target.
- kind 4: pc←jmp, and pc+4 is pushed onto the RAS.
- kind 5: pc←reg_target, and pc+4 is pushed onto the RAS.
- kind 6 with ras_count>0: pop, pc←popped value.
- kind 6 with ras_count=0: pc←reg_target, ras_err=1.
- Misaligned register target: for kinds 3, 5 and (6 with empty RAS), if reg_target[1:0]≠0, then pc←EXCP_ADRS, epc←pc, misalign=1, and no push occurs.
- RAS push when full: circular overwrite of the oldest entry. ras_count saturates at RAS_DEPTH.
- RAS pop: decrements ras_count. The stack pointer wraps modulo RAS_DEPTH.

## Timing
- One-cycle latency: inputs sampled at an edge determine pc after that edge. No combinational path from inputs to pc.
- link is the only combinational output. It follows pc.
- taken, ras_err and misalign are valid in the cycle after the deciding edge. They are cleared on any cycle without their cause, including stall.
- A stall lasting N cycles holds pc for exactly N edges. The instruction is re-evaluated on the first non-stall edge.
- Reset asserted mid-sequence wins on that edge, regardless of excp, stall or kind.
- excp and eret together: excp wins, so epc←pc (the old epc is lost).
- pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Branch offset crossing zero wraps modulo 2^XLEN.

## Test plan
- Reset and sequential fetch: reset for 2 cycles, then kind=0 for 3 cycles.
  - Expect pc = 0, 4, 8, 12; link = pc+4; epc = 0; ras_count = 0.
- Conditional branch with pc=0x100, imm=16'hFFFE.
  - cond=ltz, cmp_val=-1: expect pc=0xFC, taken=1.
  - cond=ltz, cmp_val=0: expect pc=0x104, taken=0.
  - cond=gez, cmp_val=0: expect taken=1.
- Call and return nesting with RAS_DEPTH=4.
  - Five calls (kind 4) from pc 0x10, 0x20, 0x30, 0x40, 0x50: expect ras_count saturates at 4.
  - Four returns: expect pc = 0x54, 0x44, 0x34, 0x24.
  - Fifth return with reg_target=0x200: expect pc=0x200, ras_err=1.
- Exception and eret with pc=0x40.
  - excp with stall=1: expect pc=0x80, epc=0x40.
  - eret: expect pc=0x40.
  - excp and eret in the same cycle: expect pc=0x80, epc updated.
- Misaligned register target: kind=3, reg_target=0x202, pc=0x10.
  - Expect pc=0x80, epc=0x10, misalign=1 for one cycle.
  - kind=5 with the same target: expect ras_count unchanged.
- Stall and wrap: pc=0xFFFF_FFFC, stall for 3 cycles, then kind=0.
  - Expect pc held for 3 edges, then pc=0.
  - Reset asserted during the stall: expect pc=START_ADRS on the next edge.
